// File: rtl/mem_responder_if.sv
// Valid/ready request and one-shot response bundle
// between the multi-cycle controller and its memory.
interface mem_responder_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory with WAIT_CYCLES wait states per access.
// Define MEM_ALIGN_CHECK_EN to add resp_err for misaligned addresses.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_responder_if.slave bus,
  output logic       busy,
  output logic [1:0] state
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic       resp_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;
  localparam logic [3:0] WAIT4  = 4'(WAIT_CYCLES);
  localparam int         DEPTH  = 1 << ADDR_W;

  logic [1:0]        st;
  logic [1:0]        nxt;
  logic [3:0]        cnt;
  logic              accept;
  logic              do_op;
  logic              mis;

  logic              cap_we;
  logic [ADDR_W-1:0] cap_idx;
  logic [DATA_W-1:0] cap_wdata;
  logic              op_we;
  logic [ADDR_W-1:0] op_idx;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic unused_addr;
  assign unused_addr = ^{bus.req_addr[31:ADDR_W+2],
                         bus.req_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt = S_IDLE;
    unique case (st)
      S_IDLE: begin
        if (accept)
          nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        else
          nxt = S_IDLE;
      end
      S_WAIT:  nxt = (cnt == 4'd1) ? S_RESP : S_WAIT;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (st == S_IDLE);
    bus.resp_valid = (st == S_RESP);
    busy           = (st != S_IDLE);
    state          = st;
    accept         = bus.req_valid && (st == S_IDLE);
    do_op          = 1'b0;
    if (!rst) begin
      if (st == S_IDLE)
        do_op = accept && (WAIT_CYCLES == 0);
      else if (st == S_WAIT)
        do_op = (cnt == 4'd1);
    end
  end

  // Zero-wait accesses execute straight from the live request.
  always_comb begin
    if (st == S_IDLE) begin
      op_we    = bus.req_we;
      op_idx   = bus.req_addr[ADDR_W+1:2];
      op_wdata = bus.req_wdata;
    end else begin
      op_we    = cap_we;
      op_idx   = cap_idx;
      op_wdata = cap_wdata;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic [1:0] cap_lo;
  logic [1:0] op_lo;

  assign op_lo = (st == S_IDLE) ? bus.req_addr[1:0] : cap_lo;
  assign mis   = (op_lo != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cap_lo <= 2'b00;
    else if (accept) cap_lo <= bus.req_addr[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        resp_err <= 1'b0;
    else if (do_op) resp_err <= mis;
  end
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cnt       <= WAIT4;
      cap_we    <= bus.req_we;
      cap_idx   <= bus.req_addr[ADDR_W+1:2];
      cap_wdata <= bus.req_wdata;
    end else if (st == S_WAIT) begin
      cnt       <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_op && op_we && !mis)
      mem[op_idx] <= op_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata_q <= '0;
    else if (do_op) begin
      if (mis)        rdata_q <= '0;
      else if (op_we) rdata_q <= op_wdata;
      else            rdata_q <= mem[op_idx];
    end
  end

  assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed steps plus
// random accesses against an associative-array memory model.
module tb_mem_responder;

  localparam int W  = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [1:0] state;
`ifdef MEM_ALIGN_CHECK_EN
  logic       resp_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model [int];

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(DW)) bus ();

  mem_responder #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .busy(busy),
    .state(state)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .resp_err(resp_err)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (1 << AW));
  endfunction

  // Call at a negedge with the responder idle.
  task automatic access(input bit we, input logic [31:0] a,
                        input logic [31:0] d);
    logic [31:0] exp;
    bit known;
    bit mis;
    chk("ready_before", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`endif
    known = 1'b1;
    exp   = 32'h0;
    if (mis)
      exp = 32'h0;
    else if (we) begin
      exp = d;
      model[widx(a)] = d;
    end else if (model.exists(widx(a)))
      exp = model[widx(a)];
    else
      known = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    for (int k = 0; k <= W; k++) begin
      if (k > 0) @(negedge clk);
      chk("ready_busy", 32'(bus.req_ready), 0);
      chk("busy", 32'(busy), 1);
      chk("resp_valid", 32'(bus.resp_valid), 32'(k == W));
      chk("state", 32'(state), (k == W) ? 2 : 1);
      if (k == W && known) chk("rdata", bus.resp_rdata, exp);
`ifdef MEM_ALIGN_CHECK_EN
      if (k == W) chk("resp_err", 32'(resp_err), 32'(mis));
`endif
    end
    @(negedge clk);
    chk("ready_after", 32'(bus.req_ready), 1);
    chk("resp_done", 32'(bus.resp_valid), 0);
    chk("busy_after", 32'(busy), 0);
    chk("state_after", 32'(state), 0);
    if (known) chk("rdata_hold", bus.resp_rdata, exp);
  endtask

  initial begin
    int last_acc;
    int accepts;
    int resps;
    bit was_ready;
    bit cur_we;
    logic [31:0] q [$];
    logic [31:0] a;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_resp", 32'(bus.resp_valid), 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("rst_err", 32'(resp_err), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    access(1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b0, 32'h10, 32'h0);
    access(1'b1, 32'h0, 32'h12345678);
    access(1'b0, 32'h0, 32'h0);
    // Upper address bits alias onto the same word.
    access(1'b0, 32'h8000_0400, 32'h0);

    // Hold req_valid high across busy periods.
    last_acc = -1;
    accepts  = 0;
    resps    = 0;
    cur_we   = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = cur_we;
    bus.req_addr  = 32'h4;
    bus.req_wdata = 32'h1;
    was_ready = bus.req_ready;
    for (int c = 1; c <= 8 * (W + 2); c++) begin
      @(negedge clk);
      if (was_ready) begin
        accepts++;
        if (last_acc >= 0) chk("held_interval", c - last_acc, W + 2);
        last_acc = c;
        if (cur_we) model[1] = 32'h1;
        q.push_back(model[1]);
        cur_we = ~cur_we;
        bus.req_we = cur_we;
      end
      if (bus.resp_valid) begin
        resps++;
        chk("held_resp_pending", 32'(q.size() > 0), 1);
        if (q.size() > 0) chk("held_rdata", bus.resp_rdata, q.pop_front());
      end
      was_ready = bus.req_ready;
    end
    bus.req_valid = 1'b0;
    for (int c = 0; c < W + 2; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        resps++;
        chk("held_resp_pending", 32'(q.size() > 0), 1);
        if (q.size() > 0) chk("held_rdata", bus.resp_rdata, q.pop_front());
      end
    end
    chk("held_accepts", accepts, 8);
    chk("held_resps", resps, accepts);
    chk("held_idle", 32'(state), 0);

    // Reset during an access in flight.
    access(1'b1, 32'h8, 32'h0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h8;
    bus.req_wdata = 32'hAAAA5555;
    @(posedge clk);
    if (W == 0) model[2] = 32'hAAAA5555;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_state", 32'(state), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(bus.req_ready), 1);
    chk("midrst_resp", 32'(bus.resp_valid), 0);
    chk("midrst_rdata", bus.resp_rdata, 0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_noresp", 32'(bus.resp_valid), 0);
    end
    rst = 1'b0;
    for (int c = 0; c < W + 2; c++) begin
      @(negedge clk);
      chk("postrst_noresp", 32'(bus.resp_valid), 0);
    end
    access(1'b0, 32'h8, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
    access(1'b1, 32'h20, 32'h13572468);
    access(1'b1, 32'h22, 32'hFFFFFFFF);
    access(1'b0, 32'h20, 32'h0);
    access(1'b0, 32'h21, 32'h0);
`endif

    for (int i = 0; i < 60; i++) begin
      a = ($urandom & 32'hFFFF_FC00)
        | (32'($urandom_range(0, 15)) << 2)
        | 32'($urandom_range(0, 3));
      access(1'($urandom), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
